// File: rtl/pdh_capture_buffer_if.sv
// Sample stream and readback port of the PDH capture buffer.
// master = sample source / DMA reader, slave = capture buffer.
interface pdh_capture_buffer_if #(
  parameter int CH_W = 16
);
  logic            sample_valid_i;
  logic [CH_W-1:0] ch0_i;
  logic [CH_W-1:0] ch1_i;
  logic [CH_W-1:0] ch2_i;
  logic [CH_W-1:0] ch3_i;
  logic [31:0]     rd_addr_i;
  logic [63:0]     rd_data_o;

  modport master (
    output sample_valid_i, ch0_i, ch1_i,
    output ch2_i, ch3_i, rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  sample_valid_i, ch0_i, ch1_i,
    input  ch2_i, ch3_i, rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/pdh_capture_buffer.sv
// Packs four PDH channels per decimated sample into a block RAM
// and exposes a registered read port for the DMA engine.
module pdh_capture_buffer #(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 14,
  parameter int CH_W   = 16
) (
  input  logic              aclk,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic [15:0]       decim_i,
  pdh_capture_buffer_if.slave bus,
  output logic              capture_busy_o,
  output logic              capture_done_o,
  output logic [ADDR_W:0]   wr_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state, state_n;

  logic              arm_r;
  logic              arm_edge;
  logic              in_cap;
  logic              wr_en;
  logic              last_wr;
  logic              start;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       decim_cnt;
  logic [4*CH_W-1:0] wdata;
  logic              unused_hi;

  logic [4*CH_W-1:0] mem [DEPTH];

  assign arm_edge = arm_i & ~arm_r;
  assign in_cap   = (state == ST_CAPTURE);
  assign wr_en    = in_cap & bus.sample_valid_i
                  & (decim_cnt == 16'd0);
  assign last_wr  = wr_en
                  & (wr_ptr == ADDR_W'(DEPTH - 1));
  assign wdata    = {bus.ch3_i, bus.ch2_i,
                     bus.ch1_i, bus.ch0_i};
  assign unused_hi = ^bus.rd_addr_i;

  assign capture_busy_o = in_cap;
  assign capture_done_o = (state == ST_DONE);

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      arm_r <= 1'b0;
    end else begin
      state <= state_n;
      arm_r <= arm_i;
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_edge) begin
          state_n = ST_CAPTURE;
          start   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (last_wr) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (arm_edge) begin
          state_n = ST_CAPTURE;
          start   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Counters clear on the same edge that enters capture.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      wr_count_o <= '0;
      decim_cnt  <= '0;
    end else if (start) begin
      wr_ptr     <= '0;
      wr_count_o <= '0;
      decim_cnt  <= '0;
    end else if (in_cap && bus.sample_valid_i) begin
      if (decim_cnt == 16'd0) begin
        wr_ptr    <= wr_ptr + 1'b1;
        decim_cnt <= decim_i;
        if (wr_count_o != (ADDR_W+1)'(DEPTH))
          wr_count_o <= wr_count_o + 1'b1;
      end else begin
        decim_cnt <= decim_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Read-first: a same-address write lands after this read.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) bus.rd_data_o <= '0;
    else bus.rd_data_o <= mem[bus.rd_addr_i[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_pdh_capture_buffer.sv
// Directed bench for pdh_capture_buffer with a 16-word RAM.
// Each task drives one scenario and checks its own results.
module tb_pdh_capture_buffer;

  logic        aclk = 1'b0;
  logic        rst_i;
  logic        arm_i;
  logic [15:0] decim_i;
  logic        busy;
  logic        done;
  logic [4:0]  wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  pdh_capture_buffer_if #(.CH_W(16)) bus ();

  pdh_capture_buffer #(
    .DEPTH(16), .ADDR_W(4), .CH_W(16)
  ) dut (
    .aclk(aclk),
    .rst_i(rst_i),
    .arm_i(arm_i),
    .decim_i(decim_i),
    .bus(bus),
    .capture_busy_o(busy),
    .capture_done_o(done),
    .wr_count_o(wr_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] w(int n);
    logic [15:0] c;
    c = 16'(n);
    return {16'hFFFF - c, 16'h8000 | c,
            c ^ 16'h5A5A, c};
  endfunction

  task automatic set_ch(int n);
    logic [63:0] v;
    v = w(n);
    bus.ch0_i = v[15:0];
    bus.ch1_i = v[31:16];
    bus.ch2_i = v[47:32];
    bus.ch3_i = v[63:48];
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic rearm();
    arm_i = 1'b0;
    cyc();
    arm_i = 1'b1;
    cyc();
  endtask

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_cnt", 64'(wr_count), 64'd0);
    chk("reset_rd", bus.rd_data_o, 64'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic test_basic();
    int busy_cyc;
    decim_i = 16'd0;
    arm_i = 1'b1;
    cyc();
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_cnt", 64'(wr_count), 64'd0);
    busy_cyc = 0;
    for (int n = 0; n < 16; n++) begin
      if (busy) busy_cyc++;
      set_ch(n);
      bus.sample_valid_i = 1'b1;
      cyc();
    end
    bus.sample_valid_i = 1'b0;
    chk("basic_busy_cycles", 64'(busy_cyc), 64'd16);
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_busy_off", 64'(busy), 64'd0);
    chk("basic_cnt", 64'(wr_count), 64'd16);
    for (int k = 0; k < 16; k++) begin
      bus.rd_addr_i = 32'(k);
      cyc();
      chk($sformatf("basic_rd%0d", k),
          bus.rd_data_o, w(k));
    end
  endtask

  task automatic test_rd_alias();
    bus.rd_addr_i = 32'd5;
    cyc();
    bus.rd_addr_i = 32'h13;
    #2;
    chk("alias_before", bus.rd_data_o, w(5));
    cyc();
    chk("alias_0x13", bus.rd_data_o, w(3));
  endtask

  task automatic test_decim();
    int n;
    decim_i = 16'd3;
    rearm();
    chk("decim_busy", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin
      set_ch(n);
      bus.sample_valid_i = 1'b1;
      cyc();
      n++;
    end
    bus.sample_valid_i = 1'b0;
    chk("decim_strobes", 64'(n), 64'd61);
    chk("decim_cnt", 64'(wr_count), 64'd16);
    for (int k = 0; k < 16; k += 5) begin
      bus.rd_addr_i = 32'(k);
      cyc();
      chk($sformatf("decim_rd%0d", k),
          bus.rd_data_o, w(4 * k));
    end
  endtask

  task automatic test_rearm();
    decim_i = 16'd0;
    rearm();
    chk("rearm_cnt", 64'(wr_count), 64'd0);
    chk("rearm_busy", 64'(busy), 64'd1);
    for (int n = 0; n < 16; n++) begin
      set_ch(100 + n);
      bus.sample_valid_i = 1'b1;
      cyc();
    end
    bus.sample_valid_i = 1'b0;
    chk("rearm_done", 64'(done), 64'd1);
    for (int k = 0; k < 16; k += 7) begin
      bus.rd_addr_i = 32'(k);
      cyc();
      chk($sformatf("rearm_rd%0d", k),
          bus.rd_data_o, w(100 + k));
    end
  endtask

  task automatic test_arm_hold();
    rearm();
    for (int i = 0; i < 100; i++) begin
      set_ch(200 + i);
      bus.sample_valid_i = 1'b1;
      cyc();
    end
    bus.sample_valid_i = 1'b0;
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_cnt", 64'(wr_count), 64'd16);
    bus.rd_addr_i = 32'd15;
    cyc();
    chk("hold_rd15", bus.rd_data_o, w(215));
    bus.rd_addr_i = 32'd0;
    cyc();
    chk("hold_rd0", bus.rd_data_o, w(200));
  endtask

  task automatic test_mid_arm();
    rearm();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) arm_i = 1'b0;
      if (i == 6) arm_i = 1'b1;
      set_ch(300 + i);
      bus.sample_valid_i = 1'b1;
      cyc();
      if (i == 6)
        chk("mid_cnt", 64'(wr_count), 64'd7);
    end
    bus.sample_valid_i = 1'b0;
    chk("mid_done", 64'(done), 64'd1);
    chk("mid_final_cnt", 64'(wr_count), 64'd16);
    bus.rd_addr_i = 32'd6;
    cyc();
    chk("mid_rd6", bus.rd_data_o, w(306));
  endtask

  task automatic test_reset_mid();
    int bad;
    rearm();
    for (int i = 0; i < 7; i++) begin
      set_ch(400 + i);
      bus.sample_valid_i = 1'b1;
      cyc();
    end
    chk("rstmid_cnt7", 64'(wr_count), 64'd7);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    chk("rstmid_cnt", 64'(wr_count), 64'd0);
    chk("rstmid_rd", bus.rd_data_o, 64'd0);
    arm_i = 1'b0;
    #1;
    rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (busy || done || wr_count != 5'd0) bad++;
    end
    chk("rstmid_stay_idle", 64'(bad), 64'd0);
    bus.sample_valid_i = 1'b0;
    arm_i = 1'b1;
    cyc();
    chk("rstmid_rearm", 64'(busy), 64'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    arm_i = 1'b0;
    decim_i = 16'd0;
    bus.sample_valid_i = 1'b0;
    bus.rd_addr_i = 32'd0;
    set_ch(0);
    test_reset();
    test_basic();
    test_rd_alias();
    test_decim();
    test_rearm();
    test_arm_hold();
    test_mid_arm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
